// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : datapath_pkg                                                 |
// | Description : Shared constants for the datapath controller: default       |
// |               result width, instruction field positions and the FSM        |
// |               state encoding.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package datapath_pkg;

    localparam int WORD_SIZE = 32;

    // Instruction word: [8:6] alu op, [5:4] addr1, [3:2] addr2, [1:0] addr3
    localparam int INSTR_W   = 9;
    localparam int ALU_W     = 3;
    localparam int ADDR_W    = 2;
    localparam int ALU_MSB   = 8;
    localparam int ALU_LSB   = 6;
    localparam int ADDR1_MSB = 5;
    localparam int ADDR1_LSB = 4;
    localparam int ADDR2_MSB = 3;
    localparam int ADDR2_LSB = 2;
    localparam int ADDR3_MSB = 1;
    localparam int ADDR3_LSB = 0;

    localparam int RETIRED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RETIRE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_fifo                                                    |
// | Description : Instruction queue for datapath_ctrl. FIFO_DEPTH must be a    |
// |               power of two (minimum 2) so the pointers wrap naturally.     |
// | Ports       : clk, rst (async, active-low)                                 |
// |               push/push_data - write request, ignored while full           |
// |               pop/pop_data   - read request, ignored while empty;          |
// |                                pop_data always shows the queue head        |
// |               full/empty     - derived from registered occupancy only      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctrl_fifo
    import datapath_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_q == C_DEPTH);
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointer overflow is the modulo wrap.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty queue never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/datapath_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : datapath_ctrl                                                |
// | Description : Queues 9-bit instructions and sequences each one through     |
// |               IDLE -> SETUP -> WRITE -> RETIRE, driving register-file      |
// |               addresses, ALU select and write enable of an external        |
// |               datapath and capturing its result.                           |
// | Ports       : clk, rst (async, active-low)                                 |
// |               in_valid/in_ready/in_instr - instruction push handshake      |
// |               addr1/addr2/addr3/alu/wr   - datapath control               |
// |               dp_result/dp_cout          - datapath result inputs         |
// |               out_result/out_cout        - result of last retired instr   |
// |               done/busy/retired          - status                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module datapath_ctrl #(
    parameter int WORD_SIZE  = datapath_pkg::WORD_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [datapath_pkg::INSTR_W-1:0]   in_instr,
    output logic [datapath_pkg::ADDR_W-1:0]    addr1,
    output logic [datapath_pkg::ADDR_W-1:0]    addr2,
    output logic [datapath_pkg::ADDR_W-1:0]    addr3,
    output logic [datapath_pkg::ALU_W-1:0]     alu,
    output logic                               wr,
    input  logic [WORD_SIZE-1:0]               dp_result,
    input  logic                               dp_cout,
    output logic [WORD_SIZE-1:0]               out_result,
    output logic                               out_cout,
    output logic                               done,
    output logic                               busy,
    output logic [datapath_pkg::RETIRED_W-1:0] retired
);

    import datapath_pkg::state_e;
    import datapath_pkg::ST_IDLE;
    import datapath_pkg::ST_SETUP;
    import datapath_pkg::ST_WRITE;
    import datapath_pkg::ST_RETIRE;
    import datapath_pkg::INSTR_W;
    import datapath_pkg::ADDR_W;
    import datapath_pkg::ALU_W;
    import datapath_pkg::RETIRED_W;
    import datapath_pkg::ALU_MSB;
    import datapath_pkg::ALU_LSB;
    import datapath_pkg::ADDR1_MSB;
    import datapath_pkg::ADDR1_LSB;
    import datapath_pkg::ADDR2_MSB;
    import datapath_pkg::ADDR2_LSB;
    import datapath_pkg::ADDR3_MSB;
    import datapath_pkg::ADDR3_LSB;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr1_q, addr1_d;
    logic [ADDR_W-1:0]      addr2_q, addr2_d;
    logic [ADDR_W-1:0]      addr3_q, addr3_d;
    logic [ALU_W-1:0]       alu_q, alu_d;
    logic [WORD_SIZE-1:0]   result_q, result_d;
    logic                   cout_q, cout_d;
    logic [RETIRED_W-1:0]   retired_q, retired_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [INSTR_W-1:0]     fifo_head;

    // The queue gates push with its own registered full flag, so in_ready
    // never depends on a same-cycle pop.
    ctrl_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_instr),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        addr3_d   = addr3_q;
        alu_d     = alu_q;
        result_d  = result_q;
        cout_d    = cout_q;
        retired_d = retired_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_d    = fifo_head[ALU_MSB:ALU_LSB];
                    addr1_d  = fifo_head[ADDR1_MSB:ADDR1_LSB];
                    addr2_d  = fifo_head[ADDR2_MSB:ADDR2_LSB];
                    addr3_d  = fifo_head[ADDR3_MSB:ADDR3_LSB];
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Capture on the edge that ends WRITE; the counter moves at the
                // same edge so it is already updated while done is high.
                result_d  = dp_result;
                cout_d    = dp_cout;
                retired_d = retired_q + 1'b1;
                state_d   = ST_RETIRE;
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr1_q   <= '0;
            addr2_q   <= '0;
            addr3_q   <= '0;
            alu_q     <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            addr3_q   <= addr3_d;
            alu_q     <= alu_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            retired_q <= retired_d;
        end
    end

    assign in_ready   = !fifo_full;
    assign addr1      = addr1_q;
    assign addr2      = addr2_q;
    assign addr3      = addr3_q;
    assign alu        = alu_q;
    assign wr         = (state_q == ST_WRITE);
    assign done       = (state_q == ST_RETIRE);
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign out_result = result_q;
    assign out_cout   = cout_q;
    assign retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_datapath_ctrl                                             |
// | Description : Directed self-checking bench for datapath_ctrl. A monitor    |
// |               tracks expected issue order, result capture and the retired  |
// |               count; the main sequence covers reset, single issue,         |
// |               result hold, back-pressure, mid-instruction reset and wrap.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_datapath_ctrl;

    localparam int WS = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [8:0]    in_instr;
    logic [1:0]    addr1, addr2, addr3;
    logic [2:0]    alu;
    logic          wr;
    logic [WS-1:0] dp_result;
    logic          dp_cout;
    logic [WS-1:0] out_result;
    logic          out_cout;
    logic          done;
    logic          busy;
    logic [7:0]    retired;

    // Datapath model: during WRITE the result depends on the issued fields;
    // outside WRITE it is deliberately different so a mistimed capture shows.
    logic [WS-1:0] dp_wr_val;
    logic          dp_wr_cout;

    assign dp_result = wr ? (dp_wr_val ^ {23'd0, alu, addr1, addr2, addr3}) : ~dp_wr_val;
    assign dp_cout   = wr ? dp_wr_cout : ~dp_wr_cout;

    datapath_ctrl #(
        .WORD_SIZE  (WS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr3      (addr3),
        .alu        (alu),
        .wr         (wr),
        .dp_result  (dp_result),
        .dp_cout    (dp_cout),
        .out_result (out_result),
        .out_cout   (out_cout),
        .done       (done),
        .busy       (busy),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] cur_instr;
    logic       pending;
    logic       prev_wr;
    logic [7:0] exp_retired;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: issue order at WRITE, capture and counter at RETIRE.
    always @(negedge clk) begin
        if (rst) begin
            if (wr) begin
                check("wr_single_cycle", 64'(prev_wr), 64'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 64'(1), 64'(0));
                end else begin
                    cur_instr = exp_q.pop_front();
                    check("issue_order", 64'({alu, addr1, addr2, addr3}), 64'(cur_instr));
                    pending = 1'b1;
                end
            end
            if (done) begin
                check("done_has_instr", 64'(pending), 64'(1));
                exp_retired = exp_retired + 8'd1;
                check("retired_count", 64'(retired), 64'(exp_retired));
                check("capture_result", 64'(out_result), 64'(dp_wr_val ^ {23'd0, cur_instr}));
                check("capture_cout", 64'(out_cout), 64'(dp_wr_cout));
                pending = 1'b0;
            end
            prev_wr = wr;
        end
    end

    task automatic send1(input logic [8:0] instr);
        @(posedge clk);
        #1;
        in_instr = instr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(instr);
    endtask

    // Holds in_valid across n instructions; reports how many had been
    // accepted the first time in_ready was seen low (-1 if never).
    task automatic push_stream(input int n, input int seed, output int acc_at_drop);
        int acc;
        int w;
        logic [8:0] v;
        acc         = 0;
        acc_at_drop = -1;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            v        = 9'(seed + i * 37);
            in_instr = v;
            in_valid = 1'b1;
            w        = 0;
            @(negedge clk);
            while (!in_ready && w < 50) begin
                if (acc_at_drop < 0) acc_at_drop = acc;
                w++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check("push_timeout", 64'(in_ready), 64'(1));
                break;
            end
            @(posedge clk);
            #1;
            exp_q.push_back(v);
            acc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int w;
        w = 0;
        @(negedge clk);
        while (!done && w < budget) begin
            w++;
            @(negedge clk);
        end
        check(tag, 64'(done), 64'(1));
    endtask

    task automatic wait_retired(input string tag, input logic [7:0] target, input int budget);
        int w;
        w = 0;
        @(negedge clk);
        while (retired !== target && w < budget) begin
            w++;
            @(negedge clk);
        end
        check(tag, 64'(retired), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int drop_at;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        dp_wr_val   = '0;
        dp_wr_cout  = 1'b0;
        pending     = 1'b0;
        prev_wr     = 1'b0;
        exp_retired = '0;
        cur_instr   = '0;

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_wr", 64'(wr), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_addrs_alu", 64'({alu, addr1, addr2, addr3}), 64'(0));
        check("rst_out_result", 64'(out_result), 64'(0));
        check("rst_out_cout", 64'(out_cout), 64'(0));
        check("rst_retired", 64'(retired), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_busy", 64'(busy), 64'(0));

        // Single instruction: latency and field decode.
        dp_wr_val  = 32'hA5A5_0F0F;
        dp_wr_cout = 1'b0;
        send1(9'b001_01_01_01);
        @(negedge clk);                         // after push edge N
        check("n0_busy", 64'(busy), 64'(1));
        check("n0_wr", 64'(wr), 64'(0));
        @(negedge clk);                         // after N+1: SETUP
        check("setup_addr1", 64'(addr1), 64'(1));
        check("setup_addr2", 64'(addr2), 64'(1));
        check("setup_addr3", 64'(addr3), 64'(1));
        check("setup_alu", 64'(alu), 64'(1));
        check("setup_wr", 64'(wr), 64'(0));
        @(negedge clk);                         // after N+2: WRITE
        check("write_wr", 64'(wr), 64'(1));
        check("write_done", 64'(done), 64'(0));
        @(negedge clk);                         // after N+3: RETIRE
        check("retire_wr", 64'(wr), 64'(0));
        check("retire_done", 64'(done), 64'(1));
        check("retire_retired", 64'(retired), 64'(1));
        check("retire_result", 64'(out_result), 64'(32'hA5A5_0F5A));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("fields_held", 64'({alu, addr1, addr2, addr3}), 64'(9'b001_01_01_01));

        // All-ones result and carry are captured and held.
        @(posedge clk);
        #1;
        dp_wr_val  = 32'hFFFF_FFFF;
        dp_wr_cout = 1'b1;
        send1(9'b000_00_00_00);
        wait_done("ones_done", 20);
        check("ones_result", 64'(out_result), 64'(32'hFFFF_FFFF));
        check("ones_cout", 64'(out_cout), 64'(1));
        check("ones_retired", 64'(retired), 64'(2));
        @(posedge clk);
        #1;
        dp_wr_val  = 32'h0000_0000;
        dp_wr_cout = 1'b0;
        repeat (5) @(negedge clk);
        check("ones_result_held", 64'(out_result), 64'(32'hFFFF_FFFF));
        check("ones_cout_held", 64'(out_cout), 64'(1));

        // Back-pressure: six instructions with in_valid held.
        @(posedge clk);
        #1;
        dp_wr_val  = 32'h1357_9BDF;
        dp_wr_cout = 1'b0;
        push_stream(6, 3, drop_at);
        check("ready_drop_point", 64'(drop_at), 64'(5));
        wait_retired("stream_retired", 8'd8, 100);
        repeat (4) @(negedge clk);
        check("stream_drained", 64'(exp_q.size()), 64'(0));
        check("stream_idle", 64'(busy), 64'(0));

        // Reset during WRITE with two instructions still queued.
        push_stream(3, 100, drop_at);
        @(negedge clk);
        check("pre_rst_wr", 64'(wr), 64'(1));
        #1 rst = 1'b0;
        #1;
        check("abort_wr", 64'(wr), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_retired", 64'(retired), 64'(0));
        exp_q.delete();
        pending     = 1'b0;
        prev_wr     = 1'b0;
        exp_retired = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_release_busy", 64'(busy), 64'(0));
        check("abort_release_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", 64'({done, wr}), 64'(0));
            @(negedge clk);
        end

        // Counter wrap: 255 instructions, then one more.
        @(posedge clk);
        #1;
        dp_wr_val  = 32'h0F0F_3C3C;
        dp_wr_cout = 1'b1;
        push_stream(255, 11, drop_at);
        wait_retired("wrap_preload", 8'd255, 2000);
        repeat (4) @(negedge clk);
        send1(9'b111_10_01_00);
        wait_done("wrap_done", 20);
        check("wrap_retired_zero", 64'(retired), 64'(0));
        check("wrap_result", 64'(out_result), 64'(32'h0F0F_3C3C ^ 32'h1E4));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
